// File: rtl/led_request_arbiter.sv
// Front-panel LED bank arbiter: grants one requester at a time a timed steady/blink
// pattern and runs a walking-zero scan when idle. Define LED_ARB_PRIORITY_EN for fixed priority with preemption.
module led_request_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter int         HOLD_TICKS   = 20,
  parameter logic [7:0] IDLE_PATTERN = 8'hFE
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   TICK,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [8*NUM_REQ-1:0]   REQ_PATTERN,
  input  logic [NUM_REQ-1:0]     REQ_BLINK,
  output logic [NUM_REQ-1:0]     GNT,
  output logic [NUM_REQ-1:0]     DONE,
  output logic                   BUSY,
  output logic [7:0]             LED_OUT
);

  localparam int CNT_W = $clog2(HOLD_TICKS + 1);
  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SHOW    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [NUM_REQ-1:0] REQ_ONE   = NUM_REQ'(1'b1);
  localparam logic [7:0]         LED_DARK  = 8'hFF;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return REQ_ONE << idx;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] show_led(input logic [7:0] pat, input logic blink, input logic phase);
    return (blink && phase) ? LED_DARK : pat;
  endfunction

  // Lowest asserted index.
  function automatic logic [IDX_W-1:0] prio_pick(input logic [NUM_REQ-1:0] req);
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick  = (!found && req[IDX_W'(k)]) ? IDX_W'(k) : pick;
      found = found | req[IDX_W'(k)];
    end
    return pick;
  endfunction

  // First asserted index searching upward from ptr+1 with wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req, input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(ptr) + k) % NUM_REQ;
      pick  = (!found && req[IDX_W'(idx)]) ? IDX_W'(idx) : pick;
      found = found | req[IDX_W'(idx)];
    end
    return pick;
  endfunction

  logic [1:0]         state_r, state_s;
  logic [7:0]         led_out_r, led_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_s;
  logic [NUM_REQ-1:0] done_r, done_s;
  logic               busy_r, busy_s;
  logic               phase_r, phase_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [IDX_W-1:0]   owner_r, owner_s;
  logic [7:0]         pat_r, pat_s;
  logic               blink_r, blink_s;

  logic               grant_s;
  logic               release_s;
  logic               tick_show_s;
  logic               recover_s;
  logic [IDX_W-1:0]   winner_s;
  logic [7:0]         win_pat_s;

`ifdef LED_ARB_PRIORITY_EN
  logic               lower_req_s;

  // Fixed-priority winner and preemption detect against the current owner.
  always_comb begin
    winner_s    = prio_pick(REQ);
    lower_req_s = |(REQ & (onehot(owner_r) - REQ_ONE));
  end
`else
  logic [IDX_W-1:0]   ptr_r;

  // Round-robin winner relative to the last owner.
  always_comb begin
    winner_s = rr_pick(REQ, ptr_r);
  end
`endif

  // Pattern of the candidate winner, used only on the grant cycle.
  always_comb begin
    win_pat_s = REQ_PATTERN[{winner_s, 3'b000} +: 8];
  end

  // Per-state decision: grant, release, or hold-tick step.
  always_comb begin
    grant_s     = 1'b0;
    release_s   = 1'b0;
    tick_show_s = 1'b0;
    recover_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_s = |REQ;
      end
      ST_SHOW: begin
`ifdef LED_ARB_PRIORITY_EN
        if (lower_req_s) begin
          grant_s = 1'b1;
        end else if (!REQ[owner_r]) begin
          release_s = 1'b1;
        end else if (TICK) begin
          tick_show_s = 1'b1;
          release_s   = (cnt_r == CNT_ONE);
        end else begin
          tick_show_s = 1'b0;
        end
`else
        if (!REQ[owner_r]) begin
          release_s = 1'b1;
        end else if (TICK) begin
          tick_show_s = 1'b1;
          release_s   = (cnt_r == CNT_ONE);
        end else begin
          tick_show_s = 1'b0;
        end
`endif
      end
      ST_RELEASE: begin
        recover_s = 1'b0;
      end
      default: begin
        recover_s = 1'b1;
      end
    endcase
  end

  // Next-state values for every register.
  always_comb begin
    state_s = state_r;
    led_s   = led_out_r;
    gnt_s   = gnt_r;
    done_s  = '0;
    busy_s  = busy_r;
    phase_s = phase_r;
    cnt_s   = cnt_r;
    owner_s = owner_r;
    pat_s   = pat_r;
    blink_s = blink_r;
    if (grant_s) begin
      state_s = ST_SHOW;
      owner_s = winner_s;
      gnt_s   = onehot(winner_s);
      busy_s  = 1'b1;
      pat_s   = win_pat_s;
      blink_s = REQ_BLINK[winner_s];
      led_s   = win_pat_s;
      cnt_s   = HOLD_LOAD;
      phase_s = 1'b0;
    end else if (release_s) begin
      // Release takes precedence over the final tick step.
      state_s = ST_RELEASE;
      done_s  = gnt_r;
      gnt_s   = '0;
      busy_s  = 1'b0;
      led_s   = IDLE_PATTERN;
      cnt_s   = '0;
      phase_s = 1'b0;
    end else if (tick_show_s) begin
      cnt_s   = cnt_r - CNT_ONE;
      phase_s = ~phase_r;
      led_s   = show_led(pat_r, blink_r, ~phase_r);
    end else if (recover_s) begin
      state_s = ST_IDLE;
      gnt_s   = '0;
      busy_s  = 1'b0;
      led_s   = IDLE_PATTERN;
      cnt_s   = '0;
      phase_s = 1'b0;
    end else if (state_r == ST_RELEASE) begin
      state_s = ST_IDLE;
    end else if (state_r == ST_IDLE && TICK) begin
      led_s = rotl(led_out_r);
    end else begin
      led_s = led_out_r;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      led_out_r <= IDLE_PATTERN;
      gnt_r     <= '0;
      done_r    <= '0;
      busy_r    <= 1'b0;
      phase_r   <= 1'b0;
      cnt_r     <= '0;
      owner_r   <= '0;
      pat_r     <= IDLE_PATTERN;
      blink_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      led_out_r <= led_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
      phase_r   <= phase_s;
      cnt_r     <= cnt_s;
      owner_r   <= owner_s;
      pat_r     <= pat_s;
      blink_r   <= blink_s;
    end
  end

`ifndef LED_ARB_PRIORITY_EN
  // Round-robin pointer: reset to the top index so requester 0 wins first.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_r <= IDX_W'(NUM_REQ - 1);
    end else if (grant_s) begin
      ptr_r <= winner_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  assign GNT     = gnt_r;
  assign DONE    = done_r;
  assign BUSY    = busy_r;
  assign LED_OUT = led_out_r;

endmodule
